lsu_rmw: RTL and testbench

Load/store unit sitting directly upstream of the word-addressed data memory in the single-cycle core; it drives the memory's mem_read/mem_write/addr/write_data and consumes its combinational read_data. It implements RV32I sub-word accesses (LB/LH/LW/LBU/LHU, SB/SH/SW) on a word-only memory. Loads use lane extraction and sign/zero extension. SB/SH use a two-cycle read-modify-write that stalls the core for one cycle.

---
 rtl/lsu_rmw.sv | 166 ++++++++++++++++
 tb/tb_lsu_rmw.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only data memory.
// Loads pick a byte/half lane out of the returned word and then sign- or
// zero-extend it. SW writes the whole word in one cycle. SB/SH read the
// word, merge the new lane into it, and write it back one cycle later.
// The core is stalled during the read cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accept a request; loads and SW finish in this cycle
// WRITE | write back the merged word of an SB/SH; the core's inputs are ignored
module lsu_rmw #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] waddr_q, waddr_d;

    logic [31:0] addr_aligned;
    logic        req_fault;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign addr_aligned = {addr[31:2], 2'b00};

    // Decode the request for misalignment, out-of-range address or an illegal width code.
    always_comb begin
        req_fault = 1'b0;
        if ((funct3 == 3'd1 || funct3 == 3'd5) && addr[0])
            req_fault = 1'b1;
        if (funct3 == 3'd2 && addr[1:0] != 2'b00)
            req_fault = 1'b1;
        if (addr >= ADDR_LIMIT)
            req_fault = 1'b1;
        if (!req_write && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7))
            req_fault = 1'b1;
        if (req_write && funct3 > 3'd2)
            req_fault = 1'b1;
    end

    // Extract the addressed lane from the memory word and extend it to 32 bits.
    always_comb begin
        lane_b = 8'(mem_rdata >> {addr[1:0], 3'b000});
        lane_h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            3'd0:    load_ext = {{24{lane_b[7]}}, lane_b};
            3'd1:    load_ext = {{16{lane_h[15]}}, lane_h};
            3'd2:    load_ext = mem_rdata;
            3'd4:    load_ext = {24'h0, lane_b};
            3'd5:    load_ext = {16'h0, lane_h};
            default: load_ext = 32'h0;
        endcase
    end

    // Replace the addressed byte/half of the current word with the store data.
    always_comb begin
        merged = mem_rdata;
        if (funct3 == 3'd0) begin
            case (addr[1:0])
                2'd0: merged[7:0]   = wdata[7:0];
                2'd1: merged[15:8]  = wdata[7:0];
                2'd2: merged[23:16] = wdata[7:0];
                2'd3: merged[31:24] = wdata[7:0];
            endcase
        end else if (addr[1]) begin
            merged[31:16] = wdata[15:0];
        end else begin
            merged[15:0] = wdata[15:0];
        end
    end

    // Next-state and output decode. Reset masks every output in the same cycle.
    always_comb begin
        state_d   = state_q;
        merge_d   = merge_q;
        waddr_d   = waddr_q;
        rdata     = 32'h0;
        stall     = 1'b0;
        fault     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault) begin
                        fault = 1'b1;
                    end else if (!req_write) begin
                        mem_read = 1'b1;
                        mem_addr = addr_aligned;
                        rdata    = load_ext;
                    end else if (funct3 == 3'd2) begin
                        mem_write = 1'b1;
                        mem_addr  = addr_aligned;
                        mem_wdata = wdata;
                    end else begin
                        mem_read = 1'b1;
                        mem_addr = addr_aligned;
                        stall    = 1'b1;
                        merge_d  = merged;
                        waddr_d  = addr_aligned;
                        state_d  = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = waddr_q;
                mem_wdata = merge_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            rdata     = 32'h0;
            stall     = 1'b0;
            fault     = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_addr  = 32'h0;
            mem_wdata = 32'h0;
        end
    end

    // State, merged word and write address registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            merge_q <= 32'h0;
            waddr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            waddr_q <= waddr_d;
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: each driven cycle pushes its hand-computed
// expected outputs; a negedge monitor pops and compares them.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, fault, mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        stall;
        logic        fault;
        logic        mrd;
        logic        mwr;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    lsu_rmw #(.MEM_WORDS(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .fault     (fault),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-addressed memory with combinational read.
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_write)
            mem[mem_addr[11:2]] <= mem_wdata;
        else if (pre_we)
            mem[pre_idx] <= pre_data;
    end

    // Monitor: one expectation per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic ok;
            e = exp_q.pop_front();
            ok = (rdata === e.rdata) && (stall === e.stall) && (fault === e.fault) &&
                 (mem_read === e.mrd) && (mem_write === e.mwr);
            if (e.mrd || e.mwr)
                ok = ok && (mem_addr === e.maddr);
            if (e.mwr)
                ok = ok && (mem_wdata === e.mwdata);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got rdata=%h stall=%b fault=%b rd=%b wr=%b addr=%h wdata=%h, want rdata=%h stall=%b fault=%b rd=%b wr=%b addr=%h wdata=%h",
                         e.name, rdata, stall, fault, mem_read, mem_write, mem_addr, mem_wdata,
                         e.rdata, e.stall, e.fault, e.mrd, e.mwr, e.maddr, e.mwdata);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic v, input logic w,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] e_rdata, input logic e_stall, input logic e_fault,
                        input logic e_mrd, input logic e_mwr, input logic [31:0] e_maddr,
                        input logic [31:0] e_mwdata);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; req_valid = v; req_write = w; funct3 = f3; addr = a; wdata = wd;
        pre_we = 1'b0;
        e.name = nm; e.rdata = e_rdata; e.stall = e_stall; e.fault = e_fault;
        e.mrd = e_mrd; e.mwr = e_mwr; e.maddr = e_maddr; e.mwdata = e_mwdata;
        exp_q.push_back(e);
    endtask

    // Idle cycle that also preloads one memory word.
    task automatic preset(input logic [31:0] byte_addr, input logic [31:0] data);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
        pre_we = 1'b1; pre_idx = byte_addr[11:2]; pre_data = data;
        e.name = "preset_idle"; e.rdata = 0; e.stall = 0; e.fault = 0;
        e.mrd = 0; e.mwr = 0; e.maddr = 0; e.mwdata = 0;
        exp_q.push_back(e);
    endtask

    task automatic ld(input string nm, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] e_rdata);
        step(nm, 0, 1, 0, f3, a, 32'h0, e_rdata, 0, 0, 1, 0, {a[31:2], 2'b00}, 32'h0);
    endtask

    task automatic flt(input string nm, input logic w, input logic [2:0] f3, input logic [31:0] a);
        step(nm, 0, 1, w, f3, a, 32'hFFFF_FFFF, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'd0;
        addr = 32'h0; wdata = 32'h0; pre_we = 1'b0; pre_idx = 10'd0; pre_data = 32'h0;

        step("reset_outputs", 1, 1, 0, 3'd2, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        preset(32'h10, 32'hAABBCCDD);

        ld("lb_0x13",  3'd0, 32'h13, 32'hFFFFFFAA);
        ld("lbu_0x13", 3'd4, 32'h13, 32'h000000AA);
        ld("lh_0x12",  3'd1, 32'h12, 32'hFFFFAABB);
        ld("lhu_0x10", 3'd5, 32'h10, 32'h0000CCDD);
        ld("lb_0x10",  3'd0, 32'h10, 32'hFFFFFFDD);
        ld("lbu_0x11", 3'd4, 32'h11, 32'h000000CC);

        step("sb_read",  0, 1, 1, 3'd0, 32'h11, 32'h12345655, 0, 1, 0, 1, 0, 32'h10, 0);
        step("sb_write", 0, 1, 1, 3'd0, 32'h11, 32'h12345655, 0, 0, 0, 0, 1, 32'h10, 32'hAABB55DD);
        ld("lw_after_sb", 3'd2, 32'h10, 32'hAABB55DD);

        preset(32'h10, 32'hAABBCCDD);
        step("sh_read",  0, 1, 1, 3'd1, 32'h12, 32'h00001234, 0, 1, 0, 1, 0, 32'h10, 0);
        // The write cycle must complete even if the inputs drop away.
        step("sh_write", 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h10, 32'h1234CCDD);
        ld("lw_after_sh", 3'd2, 32'h10, 32'h1234CCDD);
        ld("lh_after_sh", 3'd1, 32'h12, 32'h00001234);

        step("sw_single", 0, 1, 1, 3'd2, 32'h14, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h14, 32'hDEADBEEF);
        ld("lw_after_sw", 3'd2, 32'h14, 32'hDEADBEEF);

        flt("fault_lw_misalign", 0, 3'd2, 32'h12);
        flt("fault_sh_misalign", 1, 3'd1, 32'h11);
        flt("fault_lb_range",    0, 3'd0, 32'h1000);
        flt("fault_load_f3_3",   0, 3'd3, 32'h10);
        flt("fault_store_f3_4",  1, 3'd4, 32'h10);
        flt("fault_sw_misalign", 1, 3'd2, 32'h16);
        ld("lw_after_faults", 3'd2, 32'h10, 32'h1234CCDD);

        preset(32'h10, 32'hAABBCCDD);
        step("sb_rst_read",  0, 1, 1, 3'd0, 32'h10, 32'h00000077, 0, 1, 0, 1, 0, 32'h10, 0);
        step("sb_rst_write", 1, 1, 1, 3'd0, 32'h10, 32'h00000077, 0, 0, 0, 0, 0, 0, 0);
        ld("lw_after_rst", 3'd2, 32'h10, 32'hAABBCCDD);

        step("b2b_sb1_read",  0, 1, 1, 3'd0, 32'h10, 32'h00000011, 0, 1, 0, 1, 0, 32'h10, 0);
        step("b2b_sb1_write", 0, 1, 1, 3'd0, 32'h10, 32'h00000011, 0, 0, 0, 0, 1, 32'h10, 32'hAABBCC11);
        step("b2b_sb2_read",  0, 1, 1, 3'd0, 32'h11, 32'h00000022, 0, 1, 0, 1, 0, 32'h10, 0);
        step("b2b_sb2_write", 0, 1, 1, 3'd0, 32'h11, 32'h00000022, 0, 0, 0, 0, 1, 32'h10, 32'hAABB2211);
        ld("lw_after_b2b", 3'd2, 32'h10, 32'hAABB2211);

        step("idle_no_req", 0, 0, 1, 3'd2, 32'h10, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);

        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
